pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 104, meaning payload width in bits: WB bundle we+alu_out+read_data+wr_addr+reg_src+jal_target = 1+32+32+5+2+32.
REQ-002 SHALL have parameter SKID, default 1, meaning 0 = single register, 1 = two-entry skid buffer.
REQ-003 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, meaning synchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1 bit, meaning synchronous discard of all held entries.
REQ-007 SHALL have port in_valid, input, 1 bit, meaning upstream stage offers a payload.
REQ-008 SHALL have port in_data, input, PAYLOAD_W bits, meaning upstream payload.
REQ-009 SHALL have port in_ready, output, 1 bit, meaning the stage accepts in_data this cycle.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning the stage presents a payload.
REQ-011 SHALL have port out_data, output, PAYLOAD_W bits, meaning the presented payload, always driven from a register.
REQ-012 SHALL have port out_ready, input, 1 bit, meaning downstream consumes the payload.
REQ-013 SHALL have port stall_cnt, output, CNT_W bits, meaning saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 SHALL treat a transfer as occurring when valid=1 and ready=1 in the same cycle, on each side independently.
REQ-015 SHALL have a latency of exactly one cycle from an accepted input to out_valid=1 when the stage was empty.
REQ-016 SHALL, when SKID=0, drive in_ready = !out_valid || out_ready (combinational path from out_ready), with states EMPTY and FULL.
REQ-017 SHALL, when SKID=1, use states EMPTY, FULL and SKID, with in_ready = (state != SKID), so that in_ready has no combinational path from out_ready.
REQ-018 SHALL, in EMPTY, move to FULL when an input is accepted, loading it into the main register.
REQ-019 SHALL, in FULL, apply these transitions:
  - input accepted with no output transfer -> SKID, with the input held in the skid register;
  - input accepted with an output transfer -> FULL, with the input loaded into the main register;
  - output transfer only -> EMPTY.
REQ-020 SHALL, in SKID, move to FULL on an output transfer, with the skid register moving into the main register.
REQ-021 SHALL ignore in_valid in SKID, since in_ready=0.
REQ-022 SHALL preserve payload order and never drop or duplicate an accepted payload.
REQ-023 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, when flush=1, go to EMPTY next cycle, clear both registers to zero, and discard any concurrent in_valid transfer.
REQ-025 SHALL give rst precedence over flush.
REQ-026 SHALL keep in_ready at its state-derived value during flush, with accepted data discarded.
REQ-027 SHALL drive out_data to zero whenever out_valid=0, so a bubble carries we=0.
REQ-028 SHALL increment stall_cnt by 1 per cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and leave it unaffected by flush.

Reset
REQ-029 SHALL, while rst=1, force state to EMPTY, out_valid=0, out_data=0, skid register=0, stall_cnt=0 and in_ready=0.
REQ-030 SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-031 SHALL discard all contents when rst is asserted mid-operation, including in SKID state, with no transfer completing in that cycle.

Structure
REQ-032 SHALL place the state encoding (EMPTY=2'd0, FULL=2'd1, SKID=2'd2) and the WB bundle field widths/offsets in the shared package defines.vh.
REQ-033 SHALL be a single module with no sub-module; the SKID=0/1 variants SHALL be selected by a generate branch.
REQ-034 SHALL allow the WB stage to instantiate it with PAYLOAD_W=104 in place of the fixed register.

Verification
REQ-035 SHALL cover streaming: SKID=1, in_valid=1 with data 1,2,3,4 on consecutive cycles and out_ready=1 -> out_data 1,2,3,4 one cycle later, in_ready constantly 1.
REQ-036 SHALL cover backpressure: SKID=1, push 0xA then 0xB while out_ready=0 -> state SKID, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB out.
REQ-037 SHALL cover flush in SKID: flush=1 concurrent with in_valid=1 (data 0xC) -> next cycle out_valid=0, out_data=0, in_ready=1, and 0xC never appears.
REQ-038 SHALL cover mid-operation reset: rst=1 asserted in state FULL -> next cycle out_valid=0, stall_cnt=0, in_ready=0; in_ready=1 after rst drops.
REQ-039 SHALL cover stall-counter saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15.
REQ-040 SHALL cover SKID=0: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 in the same cycle.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the WB pipeline stage register: FSM encoding and
// the field layout of the 104-bit writeback bundle.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  // WB bundle field widths, MSB first: we, alu_out, read_data, wr_addr, reg_src, jal_target
  localparam int unsigned WB_WE_W     = 1;
  localparam int unsigned WB_ALU_W    = 32;
  localparam int unsigned WB_RDATA_W  = 32;
  localparam int unsigned WB_WADDR_W  = 5;
  localparam int unsigned WB_REGSRC_W = 2;
  localparam int unsigned WB_JAL_W    = 32;

  localparam int unsigned WB_JAL_LSB    = 0;
  localparam int unsigned WB_REGSRC_LSB = WB_JAL_LSB + WB_JAL_W;
  localparam int unsigned WB_WADDR_LSB  = WB_REGSRC_LSB + WB_REGSRC_W;
  localparam int unsigned WB_RDATA_LSB  = WB_WADDR_LSB + WB_WADDR_W;
  localparam int unsigned WB_ALU_LSB    = WB_RDATA_LSB + WB_RDATA_W;
  localparam int unsigned WB_WE_LSB     = WB_ALU_LSB + WB_ALU_W;
  localparam int unsigned WB_BUNDLE_W   = WB_WE_LSB + WB_WE_W;

endpackage

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage: single register (SKID=0) or two-entry skid
// buffer (SKID=1, in_ready fully registered), with a saturating stall counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = WB_BUNDLE_W,
  parameter int unsigned SKID      = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_data,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     stall_cnt
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PAYLOAD_W-1:0] r_main;
  logic [PAYLOAD_W-1:0] w_main_nxt;
  logic [PAYLOAD_W-1:0] r_skid;
  logic [PAYLOAD_W-1:0] w_skid_nxt;
  logic [CNT_W-1:0]     r_stall_cnt;
  logic                 w_in_ready;
  logic                 w_in_fire;
  logic                 w_out_fire;

  generate
    if (SKID != 0) begin : g_skid
      assign w_in_ready = !rst && (r_state != ST_SKID);
    end else begin : g_single
      assign w_in_ready = !rst && ((r_state == ST_EMPTY) || out_ready);
    end
  endgenerate

  assign w_in_fire  = in_valid && w_in_ready;
  assign w_out_fire = out_valid && out_ready;

  // Main register is cleared whenever the stage empties, so a bubble
  // presents an all-zero payload (we=0) without an output mux.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_FULL;
            w_main_nxt  = in_data;
          end
        end
        ST_FULL: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_in_fire) begin
            if (SKID != 0) begin
              w_state_nxt = ST_SKID;
              w_skid_nxt  = in_data;
            end
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = '0;
          end
        end
        ST_SKID: begin
          if (w_out_fire) begin
            w_state_nxt = ST_FULL;
            w_main_nxt  = r_skid;
            w_skid_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = '0;
          w_skid_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_main;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboarded bench for pipe_stage_skid: skid variant, a 4-bit stall-counter
// copy sharing its stimulus, and a single-register variant.
module tb_pipe_stage_skid;

  localparam int unsigned W = 104;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [15:0]  stall_cnt;

  logic         sat_in_ready, sat_out_valid;
  logic [W-1:0] sat_out_data;
  logic [3:0]   sat_stall_cnt;

  logic         s0_in_valid, s0_out_ready, s0_in_ready, s0_out_valid;
  logic [W-1:0] s0_in_data, s0_out_data;
  logic [15:0]  s0_stall_cnt;

  pipe_stage_skid #(.PAYLOAD_W(W), .SKID(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.PAYLOAD_W(W), .SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(sat_in_ready),
    .out_valid(sat_out_valid), .out_data(sat_out_data), .out_ready(out_ready),
    .stall_cnt(sat_stall_cnt)
  );

  pipe_stage_skid #(.PAYLOAD_W(W), .SKID(0), .CNT_W(16)) u_s0 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(s0_in_valid), .in_data(s0_in_data), .in_ready(s0_in_ready),
    .out_valid(s0_out_valid), .out_data(s0_out_data), .out_ready(s0_out_ready),
    .stall_cnt(s0_stall_cnt)
  );

  int unsigned  total = 0;
  int unsigned  bad   = 0;
  logic [W-1:0] sb_q[$];
  bit           mon_en = 1'b0;
  int unsigned  exp_stall = 0;

  // Scoreboard and stall-counter model for u_dut, sampled mid-cycle
  always @(negedge clk) begin
    logic [W-1:0] exp_d;
    if (mon_en) begin
      total++;
      if (stall_cnt !== exp_stall[15:0]) begin
        bad++;
        $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt, exp_stall);
      end
      if (!rst && out_valid === 1'b1 && out_ready) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected got=%h want=none", out_data);
        end else begin
          exp_d = sb_q.pop_front();
          if (out_data !== exp_d) begin
            bad++;
            $display("FAIL sb_data got=%h want=%h", out_data, exp_d);
          end
        end
      end
      if (rst || flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(in_data);
      if (rst) exp_stall = 0;
      else if (out_valid && !out_ready && exp_stall < 65535) exp_stall++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s0_in_valid = 1'b0; s0_in_data = '0; s0_out_ready = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rst_out_data got=%h want=0", out_data); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall got=%0d want=0", stall_cnt); end
    total++; if (s0_in_ready !== 1'b0) begin bad++; $display("FAIL rst_s0_in_ready got=%b want=0", s0_in_ready); end
    cyc();
    rst = 1'b0; mon_en = 1'b1; exp_stall = 0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      in_valid = 1'b1; in_data = W'(i);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready i=%0d got=%b want=1", i, in_ready); end
      if (i == 1) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_empty got=%b want=0", out_valid); end
      end else begin
        total++; if (out_valid !== 1'b1 || out_data !== W'(i - 1)) begin
          bad++; $display("FAIL stream_out i=%0d got=%b/%h want=1/%h", i, out_valid, out_data, W'(i - 1));
        end
      end
    end
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_data !== W'(4)) begin bad++; $display("FAIL stream_last got=%b/%h want=1/4", out_valid, out_data); end
    cyc();
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || out_data !== '0) begin bad++; $display("FAIL stream_bubble got=%b/%h want=0/0", out_valid, out_data); end
  endtask

  task automatic test_backpressure();
    cyc(); out_ready = 1'b0; in_valid = 1'b1; in_data = W'(32'hA);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_a got=%b want=1", in_ready); end
    cyc(); in_data = W'(32'hB);
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_data !== W'(32'hA)) begin bad++; $display("FAIL bp_accept_b got=%b/%h want=1/a", in_ready, out_data); end
    cyc(); in_data = W'(32'hD);
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== W'(32'hA)) begin
      bad++; $display("FAIL bp_skid got=%b/%b/%h want=0/1/a", in_ready, out_valid, out_data);
    end
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_data !== W'(32'hA)) begin bad++; $display("FAIL bp_hold got=%b/%h want=0/a", in_ready, out_data); end
    cyc(); out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_data !== W'(32'hA)) begin bad++; $display("FAIL bp_drain_a got=%h want=a", out_data); end
    cyc();
    @(negedge clk);
    total++; if (out_data !== W'(32'hB) || in_ready !== 1'b1) begin bad++; $display("FAIL bp_drain_b got=%h/%b want=b/1", out_data, in_ready); end
    cyc();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_flush();
    cyc(); out_ready = 1'b0; in_valid = 1'b1; in_data = W'(1);
    cyc(); in_data = W'(2);
    cyc(); in_data = W'(32'hC); flush = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_skid_ready got=%b want=0", in_ready); end
    cyc(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_skid_after got=%b/%h/%b want=0/0/1", out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_c got=%b want=0", out_valid); end
    cyc(); out_ready = 1'b0; in_valid = 1'b1; in_data = W'(32'h11);
    cyc(); in_data = W'(32'h22); flush = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_full_ready got=%b want=1", in_ready); end
    cyc(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || out_data !== '0) begin bad++; $display("FAIL flush_full_after got=%b/%h want=0/0", out_valid, out_data); end
    out_ready = 1'b1;
    cyc();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_discard got=%b want=0", out_valid); end
  endtask

  task automatic test_mid_reset();
    cyc(); out_ready = 1'b0; in_valid = 1'b1; in_data = W'(5);
    cyc(); in_valid = 1'b0;
    cyc(); rst = 1'b1;
    cyc();
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || stall_cnt !== 16'd0 || in_ready !== 1'b0 || out_data !== '0) begin
      bad++; $display("FAIL midrst_full got=%b/%0d/%b/%h want=0/0/0/0", out_valid, stall_cnt, in_ready, out_data);
    end
    cyc(); rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_release got=%b want=1", in_ready); end
    in_valid = 1'b1; in_data = W'(6);
    cyc(); in_data = W'(7);
    cyc(); in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_skid_ready got=%b want=0", in_ready); end
    cyc(); rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL midrst_skid_after got=%b/%b want=0/1", out_valid, in_ready); end
    repeat (2) cyc();
  endtask

  task automatic test_saturation();
    cyc(); rst = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
    cyc(); rst = 1'b0; in_valid = 1'b1; in_data = W'(32'h99);
    cyc(); in_valid = 1'b0;
    for (int k = 2; k <= 21; k++) begin
      cyc();
      if (k == 15) begin
        @(negedge clk);
        total++; if (sat_stall_cnt !== 4'd14) begin bad++; $display("FAIL sat_pre got=%0d want=14", sat_stall_cnt); end
      end
    end
    @(negedge clk);
    total++; if (sat_stall_cnt !== 4'd15 || sat_out_data !== W'(32'h99)) begin
      bad++; $display("FAIL sat_cap got=%0d/%h want=15/99", sat_stall_cnt, sat_out_data);
    end
    cyc(); out_ready = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic test_skid0();
    cyc(); s0_out_ready = 1'b0; s0_in_valid = 1'b1; s0_in_data = W'(7);
    @(negedge clk);
    total++; if (s0_in_ready !== 1'b1 || s0_out_valid !== 1'b0) begin bad++; $display("FAIL s0_accept got=%b/%b want=1/0", s0_in_ready, s0_out_valid); end
    cyc(); s0_in_valid = 1'b0;
    @(negedge clk);
    total++; if (s0_out_valid !== 1'b1 || s0_out_data !== W'(7) || s0_in_ready !== 1'b0) begin
      bad++; $display("FAIL s0_stall got=%b/%h/%b want=1/7/0", s0_out_valid, s0_out_data, s0_in_ready);
    end
    #1 s0_out_ready = 1'b1;
    #1;
    total++; if (s0_in_ready !== 1'b1) begin bad++; $display("FAIL s0_comb_ready got=%b want=1", s0_in_ready); end
    for (int i = 1; i <= 3; i++) begin
      cyc(); s0_in_valid = 1'b1; s0_in_data = W'(32'h20 + i);
      @(negedge clk);
      if (i == 1) begin
        total++; if (s0_out_valid !== 1'b0 || s0_in_ready !== 1'b1) begin bad++; $display("FAIL s0_drained got=%b/%b want=0/1", s0_out_valid, s0_in_ready); end
      end else begin
        total++; if (s0_out_data !== W'(32'h20 + i - 1) || s0_in_ready !== 1'b1) begin
          bad++; $display("FAIL s0_stream i=%0d got=%h/%b want=%h/1", i, s0_out_data, s0_in_ready, W'(32'h20 + i - 1));
        end
      end
    end
    cyc(); s0_in_valid = 1'b0;
    @(negedge clk);
    total++; if (s0_out_data !== W'(32'h23)) begin bad++; $display("FAIL s0_last got=%h want=23", s0_out_data); end
    cyc();
    @(negedge clk);
    total++; if (s0_out_valid !== 1'b0 || s0_out_data !== '0) begin bad++; $display("FAIL s0_bubble got=%b/%h want=0/0", s0_out_valid, s0_out_data); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_mid_reset();
    test_saturation();
    test_skid0();
    cyc();
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
